// File: rtl/bsg_debounce_array_pkg.sv
// Shared helpers for the debounce array: counter width sizing only.
// No logic, no latency, no flow control.
package bsg_debounce_array_pkg;

    // Width that holds values 0..x-1, never less than one bit.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_debounce_channel.sv
// One debounce channel: sync pair, tick-gated stable counter, level, edge and hold pulses.
// Level follows a clean change stable_cnt_p+2 cycles after capture (tick_i=1); no backpressure.
module bsg_debounce_channel
    import bsg_debounce_array_pkg::*;
#(
    parameter int   stable_cnt_p = 1024,
    parameter int   hold_cnt_p   = 65536,
    parameter logic invert_p     = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tick_i,
    input  logic button_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o
);
    localparam int cnt_width_lp = safe_clog2(stable_cnt_p + 1);
    localparam logic [cnt_width_lp-1:0] stable_lp = cnt_width_lp'(stable_cnt_p);

    logic                    sync1_d, sync1_q;
    logic                    sync2_d, sync2_q;
    logic [cnt_width_lp-1:0] cnt_d, cnt_q;
    logic                    level_d, level_q;
    logic                    rise_d, rise_q;
    logic                    fall_d, fall_q;

    always_comb begin
        sync1_d = button_i ^ invert_p;
        sync2_d = sync1_q;
        // Any disagreement across the sync pair restarts the stable window, tick or not.
        if (sync1_q ^ sync2_q)
            cnt_d = '0;
        else if (tick_i && (cnt_q < stable_lp))
            cnt_d = cnt_q + cnt_width_lp'(1);
        else
            cnt_d = cnt_q;
        level_d = (cnt_q == stable_lp) ? sync2_q : level_q;
        rise_d  = level_d & ~level_q;
        fall_d  = ~level_d & level_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

    if (hold_cnt_p > 0) begin : g_hold
        localparam int hold_width_lp = safe_clog2(hold_cnt_p + 1);
        localparam logic [hold_width_lp-1:0] hold_lp = hold_width_lp'(hold_cnt_p);

        logic [hold_width_lp-1:0] hold_cnt_d, hold_cnt_q;
        logic                     hold_d, hold_q;
        logic                     hold_inc;

        // Counting only while level is high now and next cycle lets a coincident fall win.
        always_comb begin
            hold_inc   = level_q & level_d & tick_i & (hold_cnt_q < hold_lp);
            hold_cnt_d = hold_cnt_q;
            if (!(level_q && level_d))
                hold_cnt_d = '0;
            else if (hold_inc)
                hold_cnt_d = hold_cnt_q + hold_width_lp'(1);
            hold_d = hold_inc & (hold_cnt_q == (hold_lp - hold_width_lp'(1)));
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                hold_cnt_q <= '0;
                hold_q     <= 1'b0;
            end else begin
                hold_cnt_q <= hold_cnt_d;
                hold_q     <= hold_d;
            end
        end

        assign hold_o = hold_q;
    end else begin : g_no_hold
        assign hold_o = 1'b0;
    end

endmodule

// File: rtl/bsg_debounce_array.sv
// N independent debounce channels sharing one prescale tick; stable_cnt_p+2 cycle level latency.
// Pure input conditioning: every event is reported in its own cycle, no backpressure.
module bsg_debounce_array
    import bsg_debounce_array_pkg::*;
#(
    parameter int               els_p         = 4,
    parameter int               stable_cnt_p  = 1024,
    parameter int               hold_cnt_p    = 65536,
    parameter logic [els_p-1:0] invert_mask_p = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             tick_i,
    input  logic [els_p-1:0] button_i,
    output logic [els_p-1:0] level_o,
    output logic [els_p-1:0] rise_o,
    output logic [els_p-1:0] fall_o,
    output logic [els_p-1:0] hold_o
);

    for (genvar i = 0; i < els_p; i++) begin : g_ch
        bsg_debounce_channel #(
            .stable_cnt_p (stable_cnt_p),
            .hold_cnt_p   (hold_cnt_p),
            .invert_p     (invert_mask_p[i])
        ) u_ch (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .tick_i   (tick_i),
            .button_i (button_i[i]),
            .level_o  (level_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i]),
            .hold_o   (hold_o[i])
        );
    end

endmodule

// File: tb/tb_bsg_debounce_array.sv
// Scoreboard bench for bsg_debounce_array: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever the DUT raises any pulse.
module tb_bsg_debounce_array;

    localparam int         ELS    = 4;
    localparam int         STABLE = 8;
    localparam int         HOLD   = 20;
    localparam logic [3:0] INV    = 4'b0010;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       tick_i;
    logic [3:0] button_i;
    logic [3:0] level_o, rise_o, fall_o, hold_o;

    bsg_debounce_array #(
        .els_p         (ELS),
        .stable_cnt_p  (STABLE),
        .hold_cnt_p    (HOLD),
        .invert_mask_p (INV)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .tick_i   (tick_i),
        .button_i (button_i),
        .level_o  (level_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .hold_o   (hold_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         cyc;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] h;
        logic [3:0] l;
    } evt_t;

    evt_t       exp_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       slow_tick = 1'b0;
    logic [3:0] inv_mask = INV;
    logic [3:0] lvl_track = '0;
    logic [3:0] cur_lvl = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic set_act(input logic [3:0] m, input logic act);
        for (int i = 0; i < 4; i++)
            if (m[i]) button_i[i] = act ^ inv_mask[i];
    endtask

    task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] h);
        evt_t e;
        lvl_track = (lvl_track | r) & ~f;
        e.cyc = c; e.r = r; e.f = f; e.h = h; e.l = lvl_track;
        exp_q.push_back(e);
    endtask

    // Level change edge when only edges divisible by 4 carry a tick.
    function automatic int slow_level_edge(input int e0);
        int t;
        t = e0 + 2;
        while ((t % 4) != 0) t++;
        return t + 4 * (STABLE - 1) + 1;
    endfunction

    task automatic press_hold_release(input logic [3:0] m);
        int e0, r0;
        e0 = cyc + 1;
        set_act(m, 1'b1);
        push(e0 + STABLE + 2, m, '0, '0);
        push(e0 + STABLE + 2 + HOLD, '0, '0, m);
        step(40);
        r0 = cyc + 1;
        set_act(m, 1'b0);
        push(r0 + STABLE + 2, '0, m, '0);
        step(20);
    endtask

    // Tick generator: every cycle normally, only on edges divisible by 4 in slow mode.
    initial begin
        tick_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            tick_i = slow_tick ? (((cyc + 1) % 4) == 0) : 1'b1;
        end
    end

    // Monitor
    initial begin
        logic [3:0] evt;
        evt_t       e;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                cur_lvl = '0;
                continue;
            end
            evt = rise_o | fall_o | hold_o;
            if (evt != 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b hold=%b want none",
                             cyc, rise_o, fall_o, hold_o);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (e.cyc != cyc) begin
                        n_bad++;
                        $display("FAIL event_cycle got=%0d want=%0d", cyc, e.cyc);
                    end
                    chk4("rise_o", rise_o, e.r);
                    chk4("fall_o", fall_o, e.f);
                    chk4("hold_o", hold_o, e.h);
                    cur_lvl = e.l;
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event cyc=%0d got none want cyc=%0d rise=%b fall=%b hold=%b",
                         cyc, e.cyc, e.r, e.f, e.h);
                cur_lvl = e.l;
            end
            chk4("level_o", level_o, cur_lvl);
        end
    end

    // Stimulus
    initial begin
        int b, e0, r0, g0, x, tgt;
        reset_i  = 1'b1;
        button_i = INV;
        step(3);
        chk4("reset_level", level_o, 4'b0);
        chk4("reset_rise", rise_o, 4'b0);
        chk4("reset_fall", fall_o, 4'b0);
        chk4("reset_hold", hold_o, 4'b0);
        reset_i = 1'b0;
        step(100);

        // Clean press on ch0, then active-low ch1.
        press_hold_release(4'b0001);
        press_hold_release(4'b0010);

        // ch2 bounce: edges captured 3 cycles apart, last at b+12.
        b = cyc + 1;
        set_act(4'b0100, 1'b1); step(3);
        set_act(4'b0100, 1'b0); step(3);
        set_act(4'b0100, 1'b1); step(3);
        set_act(4'b0100, 1'b0); step(3);
        set_act(4'b0100, 1'b1);
        push(b + 12 + STABLE + 2, 4'b0100, '0, '0);
        push(b + 12 + STABLE + 2 + HOLD, '0, '0, 4'b0100);
        step(50);
        r0 = cyc + 1;
        set_act(4'b0100, 1'b0);
        push(r0 + STABLE + 2, '0, 4'b0100, '0);
        step(20);

        // Simultaneous events on two channels.
        press_hold_release(4'b0101);

        // Slow tick on ch3, then a 6-tick glitch.
        slow_tick = 1'b1;
        step(8);
        e0 = cyc + 1;
        set_act(4'b1000, 1'b1);
        push(slow_level_edge(e0), 4'b1000, '0, '0);
        tgt = slow_level_edge(e0) + 4;
        step(tgt - cyc);
        r0 = cyc + 1;
        set_act(4'b1000, 1'b0);
        push(slow_level_edge(r0), '0, 4'b1000, '0);
        tgt = slow_level_edge(r0) + 10;
        step(tgt - cyc);
        g0 = cyc + 1;
        set_act(4'b1000, 1'b1);
        step(24);
        set_act(4'b1000, 1'b0);
        step(60);
        slow_tick = 1'b0;
        step(5);

        // Reset mid-hold on ch0, input kept pressed through reset.
        e0 = cyc + 1;
        set_act(4'b0001, 1'b1);
        push(e0 + STABLE + 2, 4'b0001, '0, '0);
        step(15);
        #2;
        reset_i = 1'b1;
        #1;
        chk4("async_reset_level", level_o, 4'b0);
        chk4("async_reset_rise", rise_o, 4'b0);
        chk4("async_reset_fall", fall_o, 4'b0);
        chk4("async_reset_hold", hold_o, 4'b0);
        lvl_track = '0;
        step(1);
        reset_i = 1'b0;
        x = cyc + 1;
        push(x + STABLE + 2, 4'b0001, '0, '0);
        push(x + STABLE + 2 + HOLD, '0, '0, 4'b0001);
        step(40);
        r0 = cyc + 1;
        set_act(4'b0001, 1'b0);
        push(r0 + STABLE + 2, '0, 4'b0001, '0);
        step(20);

        while (exp_q.size() > 0) begin
            evt_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL unseen_event got none want cyc=%0d rise=%b fall=%b hold=%b",
                     e.cyc, e.r, e.f, e.h);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
